wb_stage_pipe: RTL and testbench
================================

# wb_stage_pipe

Registered, back-pressurable writeback stage for the RV32/RV64 pipeline, placed between the MEM stage and the register-file write port. Each accepted instruction's result is selected from the ALU result, load data or PC+4. Load data is aligned and sign/zero-extended per funct3. Results are held in a 2-entry buffer until the register file accepts them, and every retired instruction is counted.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 and 64.
- CNT_W, 32: width of the retire counter.
- OFFW, derived = $clog2(XLEN/8): byte-offset width; not user-set.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  stage can accept; transfer occurs when mem_valid && mem_ready.
- mem_sel  in  2  result source: 00 no write, 01 ALU, 10 load data, 11 PC+4.
- mem_funct3  in  3  load type; used only when mem_sel=10.
- mem_off  in  OFFW  byte offset of the load address within the XLEN word.
- mem_rd  in  5  destination register.
- mem_alu  in  XLEN  ALU result.
- mem_lmd  in  XLEN  raw load memory data, XLEN-aligned.
- mem_pc4  in  XLEN  PC+4.
- rf_ready  in  1  register file accepts a write this cycle.
- rf_we  out  1  write request.
- rf_waddr  out  5  write address.
- rf_wdata  out  XLEN  write data.
- load_err  out  1  one-cycle pulse: the popping entry is an illegal/misaligned load.
- retire_cnt  out  CNT_W  count of retired entries; wraps.

## Operation
- Formatting happens at acceptance. The formatted value, rd, a write flag and an error flag are stored in the buffer.
- Load formatting (mem_sel=10):
  - 000 LB: byte at mem_off, sign-extended.
  - 100 LBU: byte at mem_off, zero-extended.
  - 001 LH: halfword at mem_off, sign-extended.
  - 101 LHU: halfword at mem_off, zero-extended.
  - 010 LW: word at mem_off, sign-extended to XLEN (full word when XLEN=32).
  - 110 LWU (XLEN=64 only): word at mem_off, zero-extended.
  - 011 LD (XLEN=64 only): full word.
- Load errors:
  - Misaligned: LH/LHU with mem_off[0]=1; LW/LWU with mem_off[1:0]≠0; LD with mem_off≠0.
  - Illegal: funct3 111, or any XLEN=64-only encoding when XLEN=32.
  - An erroring entry has its write flag cleared and its error flag set.
- The write flag is 1 iff mem_sel≠00, mem_rd≠0 and there is no error. x0 is never written.
- Buffer: 2-entry FIFO with head/tail pointers and a 2-bit count.
  - mem_ready = (count<2), derived from registered state only; it is 0 when full even if a pop happens the same cycle.
- Head output:
  - rf_we = head valid && head write flag.
  - rf_waddr and rf_wdata come from the head entry, and are held stable while rf_we=1 and rf_ready=0.
  - When rf_we=0 (including when empty), rf_waddr and rf_wdata are 0.
- Pop conditions:
  - A writing head pops when rf_ready=1.
  - A non-writing head (no-write, rd=0, or error) pops unconditionally in the cycle it reaches the head.
- load_err = head valid && head error flag. It is combinational from the head register and lasts exactly one cycle per errored entry.
- retire_cnt increments by 1 on every pop, including non-writing and errored entries, and wraps modulo 2^CNT_W.
- Simultaneous push and pop: count is unchanged and both pointers advance.

## Timing
- Reset (async assert, released synchronously to clk by the system): count=0, pointers=0, all entry valid/flags=0, retire_cnt=0.
  - Resulting outputs: rf_we=0, rf_waddr=0, rf_wdata=0, load_err=0, mem_ready=1.
- Reset mid-operation: buffered entries are discarded without a write, and the counter returns to 0.
- Latency: an instruction accepted at edge n appears on rf_we/rf_waddr/rf_wdata in the cycle after edge n.
  - It retires at the first subsequent edge with rf_ready=1, or at edge n+1 if non-writing.
  - Minimum latency is one cycle. There is no combinational path from mem_* to rf_*.
- Throughput: one instruction per cycle while rf_ready=1.
  - With rf_ready held low, two writing entries are accepted, then mem_ready=0 until a pop.
- Ordering: writes to the register file occur in acceptance order.

## Test plan
- Reset, then mem_sel=01, rd=5, alu=0x1234_5678, rf_ready=1 → next cycle rf_we=1, waddr=5, wdata=0x1234_5678; retire_cnt=1 after the following edge.
- Loads (XLEN=32) with lmd=0x80FF_7F01:
  - LB off=3 → 0xFFFF_FF80.
  - LBU off=3 → 0x0000_0080.
  - LH off=2 → 0xFFFF_80FF.
  - LHU off=0 → 0x0000_7F01.
  - LW off=0 → 0x80FF_7F01.
- Back-pressure: rf_ready=0 with 3 back-to-back writing instructions → mem_ready drops after 2 accepts and the 3rd is held upstream.
  - Raise rf_ready → writes emerge in order over 3 cycles.
  - retire_cnt advances by 3.
- Non-writing entries: LH off=1, then rd=0 ALU op, then sel=00, with rf_ready=0.
  - All three pop without rf_we; load_err pulses once for the first; retire_cnt +3.
- Reset asserted with 2 buffered entries → immediately rf_we=0, mem_ready=1, retire_cnt=0; no write occurs.
- CNT_W=4: retire 17 instructions → retire_cnt wraps to 1.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// Writeback stage: selects and formats each accepted result, buffers it in a
// 2-entry FIFO and presents it to the register-file write port in order.
module wb_stage_pipe #(
    parameter  int XLEN  = 32,
    parameter  int CNT_W = 32,
    localparam int OFFW  = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [1:0]       mem_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [OFFW-1:0]  mem_off,
    input  logic [4:0]       mem_rd,
    input  logic [XLEN-1:0]  mem_alu,
    input  logic [XLEN-1:0]  mem_lmd,
    input  logic [XLEN-1:0]  mem_pc4,
    input  logic             rf_ready,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             load_err,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic IS64 = (XLEN == 64);

    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] lmd,
                                                 input logic [OFFW-1:0] off);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh  = lmd >> {off, 3'b000};
        res = '0;
        case (f3)
            3'b000: begin res = {XLEN{sh[7]}};  res[7:0]  = sh[7:0];  end
            3'b100: res[7:0] = sh[7:0];
            3'b001: begin res = {XLEN{sh[15]}}; res[15:0] = sh[15:0]; end
            3'b101: res[15:0] = sh[15:0];
            3'b010: begin res = {XLEN{sh[31]}}; res[31:0] = sh[31:0]; end
            3'b110: res[31:0] = sh[31:0];
            3'b011: res = sh;
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic load_bad(input logic [2:0] f3, input logic [OFFW-1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = off[0];
            3'b010:         bad = (off[1:0] != 2'b00);
            3'b110:         bad = !IS64 || (off[1:0] != 2'b00);
            3'b011:         bad = !IS64 || (off != '0);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    logic [XLEN-1:0]  data_q [2];
    logic [4:0]       rd_q   [2];
    logic [1:0]       vld_q, we_q, err_q;
    logic             head_q, tail_q;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] retire_q;

    logic             push_s, pop_s, head_vld_s, head_we_s;
    logic             new_err_s, new_we_s;
    logic [XLEN-1:0]  new_data_s;

    // Result selection, load formatting and write/error classification at acceptance
    always_comb begin
        new_data_s = '0;
        new_err_s  = 1'b0;
        case (mem_sel)
            2'b01:   new_data_s = mem_alu;
            2'b10: begin
                new_data_s = fmt_load(mem_funct3, mem_lmd, mem_off);
                new_err_s  = load_bad(mem_funct3, mem_off);
            end
            2'b11:   new_data_s = mem_pc4;
            default: new_data_s = '0;
        endcase
        new_we_s = (mem_sel != 2'b00) && (mem_rd != 5'd0) && !new_err_s;
    end

    // Handshake, pop decision and next occupancy; non-writing heads drain without rf_ready
    always_comb begin
        mem_ready  = (count_q < 2'd2);
        push_s     = mem_valid && mem_ready;
        head_vld_s = vld_q[head_q];
        head_we_s  = head_vld_s && we_q[head_q];
        pop_s      = head_vld_s && (!we_q[head_q] || rf_ready);
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Register-file port and error pulse, driven from the head entry only
    always_comb begin
        rf_we      = head_we_s;
        rf_waddr   = head_we_s ? rd_q[head_q] : 5'd0;
        rf_wdata   = head_we_s ? data_q[head_q] : '0;
        load_err   = head_vld_s && err_q[head_q];
        retire_cnt = retire_q;
    end

    // FIFO storage, pointers and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= 2'b00;
            we_q     <= 2'b00;
            err_q    <= 2'b00;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
            retire_q <= '0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= 5'd0;
            end
        end else begin
            count_q <= count_d;
            if (pop_s) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= ~head_q;
                retire_q      <= retire_q + CNT_W'(1);
            end
            if (push_s) begin
                vld_q[tail_q]  <= 1'b1;
                we_q[tail_q]   <= new_we_s;
                err_q[tail_q]  <= new_err_s;
                rd_q[tail_q]   <= mem_rd;
                data_q[tail_q] <= new_data_s;
                tail_q         <= ~tail_q;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Randomized and directed bench for wb_stage_pipe (XLEN=32, CNT_W=4) against a
// queue-based reference model of the writeback buffer.
module tb_wb_stage_pipe;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mem_valid;
    logic             mem_ready;
    logic [1:0]       mem_sel;
    logic [2:0]       mem_funct3;
    logic [1:0]       mem_off;
    logic [4:0]       mem_rd;
    logic [XLEN-1:0]  mem_alu, mem_lmd, mem_pc4;
    logic             rf_ready;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             load_err;
    logic [CNT_W-1:0] retire_cnt;

    wb_stage_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_sel(mem_sel), .mem_funct3(mem_funct3), .mem_off(mem_off), .mem_rd(mem_rd),
        .mem_alu(mem_alu), .mem_lmd(mem_lmd), .mem_pc4(mem_pc4), .rf_ready(rf_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .load_err(load_err),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        err;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t             mq[$];
    logic [CNT_W-1:0] m_cnt;
    int               n_vec = 0;
    int               n_err = 0;
    int               n_lerr = 0;
    bit               last_push;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t mk_ent(input logic [1:0] sel, input logic [2:0] f3,
                                    input logic [1:0] off, input logic [4:0] rd,
                                    input logic [31:0] alu, input logic [31:0] lmd,
                                    input logic [31:0] pc4);
        ent_t e;
        int sz;
        bit sgn;
        logic [63:0] v;
        e.err = 1'b0; e.data = 32'd0; e.rd = rd;
        if (sel == 2'd1) e.data = alu;
        else if (sel == 2'd3) e.data = pc4;
        else if (sel == 2'd2) begin
            sz = 0; sgn = 1'b0;
            case (f3)
                3'd0: begin sz = 1; sgn = 1'b1; end
                3'd4: begin sz = 1; sgn = 1'b0; end
                3'd1: begin sz = 2; sgn = 1'b1; end
                3'd5: begin sz = 2; sgn = 1'b0; end
                3'd2: begin sz = 4; sgn = 1'b1; end
                default: sz = 0;
            endcase
            if (sz == 0 || (int'(off) % sz) != 0) e.err = 1'b1;
            else begin
                v = (64'(lmd) >> (8 * int'(off))) & ((64'd1 << (8 * sz)) - 64'd1);
                if (sgn && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
                e.data = v[31:0];
            end
        end
        e.we = (sel != 2'd0) && (rd != 5'd0) && !e.err;
        return e;
    endfunction

    // Compare outputs with the model head, then advance the model by one edge
    task automatic model_cycle();
        ent_t h;
        bit pop, push;
        chk_eq("mem_ready", mem_ready, (mq.size() < 2));
        if (mq.size() > 0) begin
            h = mq[0];
            chk_eq("rf_we", rf_we, h.we);
            chk_eq("rf_waddr", rf_waddr, h.we ? h.rd : 5'd0);
            chk_eq("rf_wdata", rf_wdata, h.we ? h.data : 32'd0);
            chk_eq("load_err", load_err, h.err);
        end else begin
            chk_eq("rf_we_empty", rf_we, 1'b0);
            chk_eq("rf_wdata_empty", {rf_waddr, rf_wdata}, 37'd0);
            chk_eq("load_err_empty", load_err, 1'b0);
        end
        chk_eq("retire_cnt", retire_cnt, m_cnt);
        if (load_err === 1'b1) n_lerr++;
        pop  = (mq.size() > 0) && (!mq[0].we || rf_ready);
        push = mem_valid && (mq.size() < 2);
        if (pop) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (push) mq.push_back(mk_ent(mem_sel, mem_funct3, mem_off, mem_rd, mem_alu, mem_lmd, mem_pc4));
        last_push = push;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] off, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] lmd, input logic [31:0] pc4);
        mem_valid = v; mem_sel = sel; mem_funct3 = f3; mem_off = off; mem_rd = rd;
        mem_alu = alu; mem_lmd = lmd; mem_pc4 = pc4;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 3'd0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_eq("rst_rf_we", rf_we, 1'b0);
        chk_eq("rst_waddr_wdata", {rf_waddr, rf_wdata}, 37'd0);
        chk_eq("rst_load_err", load_err, 1'b0);
        chk_eq("rst_mem_ready", mem_ready, 1'b1);
        chk_eq("rst_retire_cnt", retire_cnt, 4'd0);
        mq.delete();
        m_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                             input logic [31:0] exp);
        rf_ready = 1'b1;
        drive(1'b1, 2'd2, f3, off, 5'd9, 32'd0, 32'h80FF_7F01, 32'd0);
        step();
        idle();
        chk_eq(tag, rf_wdata, exp);
        step();
    endtask

    initial begin : main
        logic [CNT_W-1:0] c0;
        int lerr0, guard;
        rst_n = 1'b1;
        rf_ready = 1'b0;
        idle();
        #2;
        do_reset();

        // single ALU write, then retire
        rf_ready = 1'b1;
        drive(1'b1, 2'd1, 3'd0, 2'd0, 5'd5, 32'h1234_5678, 32'd0, 32'd0);
        step();
        idle();
        chk_eq("alu_we", rf_we, 1'b1);
        chk_eq("alu_waddr", rf_waddr, 5'd5);
        chk_eq("alu_wdata", rf_wdata, 32'h1234_5678);
        step();
        chk_eq("alu_retire", retire_cnt, 4'd1);

        load_case("lb_off3", 3'd0, 2'd3, 32'hFFFF_FF80);
        load_case("lbu_off3", 3'd4, 2'd3, 32'h0000_0080);
        load_case("lh_off2", 3'd1, 2'd2, 32'hFFFF_80FF);
        load_case("lhu_off0", 3'd5, 2'd0, 32'h0000_7F01);
        load_case("lw_off0", 3'd2, 2'd0, 32'h80FF_7F01);

        // back-pressure: third instruction must wait upstream
        c0 = retire_cnt;
        rf_ready = 1'b0;
        drive(1'b1, 2'd1, 3'd0, 2'd0, 5'd1, 32'hA1, 32'd0, 32'd0); step();
        drive(1'b1, 2'd1, 3'd0, 2'd0, 5'd2, 32'hB2, 32'd0, 32'd0); step();
        drive(1'b1, 2'd3, 3'd0, 2'd0, 5'd3, 32'd0, 32'd0, 32'hC3);
        chk_eq("bp_full_ready", mem_ready, 1'b0);
        step();
        rf_ready = 1'b1;
        guard = 0;
        last_push = 1'b0;
        while (!last_push && guard < 10) begin step(); guard++; end
        chk_eq("bp_third_accepted", last_push, 1'b1);
        idle();
        repeat (3) step();
        chk_eq("bp_retire_delta", 4'(retire_cnt - c0), 4'd3);

        // non-writing entries drain with rf_ready low
        c0 = retire_cnt;
        lerr0 = n_lerr;
        rf_ready = 1'b0;
        drive(1'b1, 2'd2, 3'd1, 2'd1, 5'd7, 32'd0, 32'h1234_5678, 32'd0); step();
        drive(1'b1, 2'd1, 3'd0, 2'd0, 5'd0, 32'h55, 32'd0, 32'd0); step();
        drive(1'b1, 2'd0, 3'd0, 2'd0, 5'd4, 32'h66, 32'd0, 32'd0); step();
        idle();
        repeat (3) step();
        chk_eq("nw_lerr_pulses", n_lerr - lerr0, 1);
        chk_eq("nw_retire_delta", 4'(retire_cnt - c0), 4'd3);

        // reset with two buffered writes
        rf_ready = 1'b0;
        drive(1'b1, 2'd1, 3'd0, 2'd0, 5'd8, 32'h77, 32'd0, 32'd0); step();
        drive(1'b1, 2'd1, 3'd0, 2'd0, 5'd9, 32'h88, 32'd0, 32'd0); step();
        idle();
        do_reset();
        rf_ready = 1'b1;
        repeat (2) step();

        // counter wrap: 17 retires from reset
        do_reset();
        rf_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'd1, 3'd0, 2'd0, 5'(i % 31 + 1), 32'(i), 32'd0, 32'd0);
            step();
        end
        idle();
        repeat (2) step();
        chk_eq("cnt_wrap", retire_cnt, 4'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin idle(); do_reset(); end
            rf_ready = ($urandom_range(0, 2) != 0);
            drive(($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom, $urandom);
            step();
        end
        idle();
        rf_ready = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
